// File: rtl/fir_pkg.sv
// fir_pkg: shared sizes, state encoding and SRAM timing for the FIR MAC sequencer.
package fir_pkg;
  localparam int TAPS = 10;
  localparam int ADDR_W = 4;
  localparam int COEFF_W = 16;
  localparam int RD_LAT = 1;
  typedef enum logic [2:0] {IDLE, SHIFT, RUN, DRAIN, DONE, WRITE} state_t;
endpackage

// File: rtl/fir_tap_cnt.sv
// fir_tap_cnt: loadable tap counter that saturates at TAPS-1 and flags terminal count.
module fir_tap_cnt
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q,
  output logic              tc
);
  assign tc = q == ADDR_W'(TAPS - 1);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= d;
    else if (en && !tc) q <= q + 1'b1;
endmodule

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: per-sample FIR MAC sequencer with host coefficient write arbitration.
// Define FIR_OVERRUN_EN to build the sticky dropped-sample (oOverrun) detector.
module fir_mac_sched
  import fir_pkg::*;
(
  input  logic               iClk12M,
  input  logic               iRst,
  input  logic               iEnSample,
  input  logic               iCoeffWrReq,
  input  logic [ADDR_W-1:0]  iCoeffWrAddr,
  input  logic [COEFF_W-1:0] iCoeffWrData,
  output logic               oCoeffWrAck,
  output logic               oCsn,
  output logic               oWrn,
  output logic [ADDR_W-1:0]  oAddr,
  output logic [COEFF_W-1:0] oWrData,
  output logic               oEnDelay,
  output logic               oAccClr,
  output logic               oEnMul,
  output logic               oEnAddAcc,
  output logic [ADDR_W-1:0]  oTapIdx,
  output logic               oBusy,
  output logic               oDone,
  output logic               oOverrun
);
  state_t state, state_next;
  logic addr_tc, idx_tc, wr_go;
  assign wr_go = state_next == WRITE && iCoeffWrAddr < ADDR_W'(TAPS);
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = iEnSample ? SHIFT : iCoeffWrReq ? WRITE : IDLE;
      SHIFT:   state_next = RUN;
      RUN:     state_next = addr_tc ? DRAIN : RUN;
      DRAIN:   state_next = idx_tc && !oEnMul ? DONE : DRAIN;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge iClk12M)
    if (iRst) state <= IDLE;
    else state <= state_next;
  // Outputs are registered from the next state so they line up with state transitions.
  always_ff @(posedge iClk12M)
    if (iRst) begin
      oCsn        <= 1'b1;
      oWrn        <= 1'b1;
      oWrData     <= '0;
      oEnDelay    <= 1'b0;
      oAccClr     <= 1'b0;
      oEnMul      <= 1'b0;
      oEnAddAcc   <= 1'b0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oCoeffWrAck <= 1'b0;
    end else begin
      oCsn        <= !(state_next == RUN || wr_go);
      oWrn        <= !wr_go;
      oWrData     <= state_next == WRITE ? iCoeffWrData : oWrData;
      oEnDelay    <= state_next == SHIFT;
      oAccClr     <= state_next == SHIFT;
      oEnMul      <= state == RUN;
      oEnAddAcc   <= oEnMul;
      oBusy       <= state_next inside {SHIFT, RUN, DRAIN, DONE};
      oDone       <= state_next == DONE;
      oCoeffWrAck <= state_next == WRITE;
    end
  fir_tap_cnt u_addr (
    .clk  (iClk12M),
    .rst  (iRst),
    .load (state == SHIFT || state_next == WRITE),
    .en   (state == RUN),
    .d    (state == SHIFT ? '0 : iCoeffWrAddr),
    .q    (oAddr),
    .tc   (addr_tc)
  );
  // Tap index trails the SRAM address by the read latency, advancing with each multiply.
  fir_tap_cnt u_idx (
    .clk  (iClk12M),
    .rst  (iRst),
    .load (state == SHIFT),
    .en   (oEnMul),
    .d    ('0),
    .q    (oTapIdx),
    .tc   (idx_tc)
  );
`ifdef FIR_OVERRUN_EN
  always_ff @(posedge iClk12M)
    if (iRst) oOverrun <= 1'b0;
    else if (iEnSample && state != IDLE) oOverrun <= 1'b1;
`else
  assign oOverrun = 1'b0;
`endif
endmodule

// File: tb/tb_fir_mac_sched.sv
// tb_fir_mac_sched: directed checks of sample sequencing, coefficient writes, overrun and reset.
module tb_fir_mac_sched;
  import fir_pkg::*;
  logic clk = 0, rst = 1, en_sample = 0, wr_req = 0;
  logic [3:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic ack, csn, wrn, en_delay, acc_clr, en_mul, en_add, busy, done, ovr;
  logic [3:0] addr, tap_idx;
  logic [15:0] wdat;
  logic [15:0] ram [16] = '{default: 16'h0};
  logic [15:0] snap [16];
  logic ack15;
  int checks = 0, errors = 0;
  bit exp_ovr;
  fir_mac_sched dut (
    .iClk12M(clk), .iRst(rst), .iEnSample(en_sample), .iCoeffWrReq(wr_req),
    .iCoeffWrAddr(wr_addr), .iCoeffWrData(wr_data), .oCoeffWrAck(ack),
    .oCsn(csn), .oWrn(wrn), .oAddr(addr), .oWrData(wdat), .oEnDelay(en_delay),
    .oAccClr(acc_clr), .oEnMul(en_mul), .oEnAddAcc(en_add), .oTapIdx(tap_idx),
    .oBusy(busy), .oDone(done), .oOverrun(ovr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!csn && !wrn) ram[addr] <= wdat;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset(input string tag);
    check(tag, {csn, wrn, en_delay, acc_clr, en_mul, en_add, busy, done, ack, ovr}, 10'b1100000000);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_tap"}, tap_idx, 0);
    check({tag, "_wdat"}, wdat, 0);
  endtask
  task automatic run_sample(input int stray, input int rst_at);
    en_sample = 1;
    tick;
    en_sample = 0;
    for (int k = 1; k <= 15; k++) begin
      check("en_delay", en_delay, k == 1);
      check("acc_clr", acc_clr, k == 1);
      check("csn", csn, !(k >= 2 && k <= 11));
      check("wrn", wrn, 1);
      if (k >= 2 && k <= 11) check("addr", addr, k - 2);
      check("en_mul", en_mul, k >= 3 && k <= 12);
      if (k >= 3 && k <= 12) check("tap_idx", tap_idx, k - 3);
      check("en_add", en_add, k >= 4 && k <= 13);
      check("done", done, k == 14);
      check("busy", busy, k <= 14);
      if (k == 15) ack15 = ack;
      else check("ack_busy", ack, 0);
      if (stray != 0 && k > stray) check("overrun", ovr, exp_ovr);
      if (k == rst_at) begin
        rst = 1;
        tick;
        check_reset("mid_rst");
        rst = 0;
        return;
      end
      en_sample = k == stray;
      tick;
    end
  endtask
  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input bit ok);
    wr_req = 1;
    wr_addr = a;
    wr_data = d;
    tick;
    check("wr_ack", ack, 1);
    check("wr_csn", csn, !ok);
    check("wr_wrn", wrn, !ok);
    if (ok) begin
      check("wr_addr", addr, a);
      check("wr_data", wdat, d);
    end
    wr_req = 0;
    tick;
    check("wr_ack_low", ack, 0);
    if (ok) check("ram", ram[a], d);
  endtask
  initial begin
`ifdef FIR_OVERRUN_EN
    exp_ovr = 1;
`else
    exp_ovr = 0;
`endif
    tick;
    tick;
    check_reset("reset");
    rst = 0;
    tick;
    run_sample(0, 0);
    do_write(4'd3, 16'hA5A5, 1);
    do_write(4'd7, 16'h1111, 1);
    for (int i = 0; i < 16; i++) snap[i] = ram[i];
    do_write(4'd12, 16'hBEEF, 0);
    begin
      bit same = 1;
      for (int i = 0; i < 16; i++) if (ram[i] !== snap[i]) same = 0;
      check("ram_unchanged", same, 1);
    end
    wr_req = 1;
    wr_addr = 4'd5;
    wr_data = 16'h1234;
    run_sample(0, 0);
    check("pending_ack_once", ack15 + ack, 1);
    check("pending_ack_not_early", ack15 | ack, 1);
    wr_req = 0;
    tick;
    check("pending_ram", ram[5], 16'h1234);
    run_sample(5, 0);
    check("stray_ovr_end", ovr, exp_ovr);
    run_sample(0, 8);
    begin
      int dones = 0, busies = 0;
      for (int i = 0; i < 16; i++) begin
        tick;
        dones += int'(done);
        busies += int'(busy);
      end
      check("no_done_after_rst", dones, 0);
      check("no_busy_after_rst", busies, 0);
    end
    run_sample(0, 0);
    check("final_idle_csn", csn, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
